// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD M:SS.T stopwatch (0:00.0..9:59.9) with IDLE/RUN/PAUSE
// control, synchronised 0.1 s tick input and registered BCD digit outputs.
// Ports: clk, reset (sync, active-high), tick_in, btn_start_stop, btn_clear,
//   btn_lap -> disp_min, disp_sec_t, disp_sec_o, disp_tenth, running,
//   overflow, lap_active.
// Option macro STOPWATCH_LAP_HOLD_EN builds the lap display-hold registers.
module stopwatch_core #(
   parameter int TICK_SYNC_STAGES = 2,
   parameter bit WRAP_AT_MAX      = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [3:0] disp_min,
   output logic [3:0] disp_sec_t,
   output logic [3:0] disp_sec_o,
   output logic [3:0] disp_tenth,
   output logic       running,
   output logic       overflow,
   output logic       lap_active
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t                      state_q;
   logic [TICK_SYNC_STAGES-1:0] sync_q;
   logic                        tick_prev_q;
   logic                        tick_stb_q;
   logic                        ss_prev_q;
   logic                        clr_prev_q;
   logic [3:0]                  min_q, sect_q, seco_q, tenth_q;
   logic [3:0]                  min_d, sect_d, seco_d, tenth_d;
   logic                        run_q;
   logic                        ovf_q;
   logic                        ss_press;
   logic                        clr_press;
   logic                        at_max;

   assign ss_press  = btn_start_stop & ~ss_prev_q;
   assign clr_press = btn_clear & ~clr_prev_q;
   assign at_max    = (min_q == 4'd9) && (sect_q == 4'd5) &&
                      (seco_q == 4'd9) && (tenth_q == 4'd9);

   // Tick is data, not a clock: synchronise, then a registered edge strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         tick_prev_q <= 1'b0;
         tick_stb_q  <= 1'b0;
      end else begin
         sync_q      <= {sync_q[TICK_SYNC_STAGES-2:0], tick_in};
         tick_prev_q <= sync_q[TICK_SYNC_STAGES-1];
         tick_stb_q  <= sync_q[TICK_SYNC_STAGES-1] & ~tick_prev_q;
      end
   end

   // Ripple BCD increment; all carries settle in one cycle.
   always_comb begin
      min_d   = min_q;
      sect_d  = sect_q;
      seco_d  = seco_q;
      tenth_d = tenth_q + 4'd1;
      if (tenth_q == 4'd9) begin
         tenth_d = 4'd0;
         seco_d  = seco_q + 4'd1;
         if (seco_q == 4'd9) begin
            seco_d = 4'd0;
            sect_d = sect_q + 4'd1;
            if (sect_q == 4'd5) begin
               sect_d = 4'd0;
               min_d  = (min_q == 4'd9) ? 4'd0 : min_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         run_q      <= 1'b0;
         ovf_q      <= 1'b0;
         ss_prev_q  <= 1'b0;
         clr_prev_q <= 1'b0;
         min_q      <= 4'd0;
         sect_q     <= 4'd0;
         seco_q     <= 4'd0;
         tenth_q    <= 4'd0;
      end else begin
         ss_prev_q  <= btn_start_stop;
         clr_prev_q <= btn_clear;
         // In wrap mode overflow is a one-cycle pulse.
         if (WRAP_AT_MAX) ovf_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ss_press) begin
                  state_q <= RUN;
                  run_q   <= 1'b1;
               end
            end
            RUN: begin
               // A stop press swallows a coincident tick.
               if (ss_press) begin
                  state_q <= PAUSE;
                  run_q   <= 1'b0;
               end else if (tick_stb_q) begin
                  if (at_max && !WRAP_AT_MAX) begin
                     ovf_q <= 1'b1;
                  end else begin
                     min_q   <= min_d;
                     sect_q  <= sect_d;
                     seco_q  <= seco_d;
                     tenth_q <= tenth_d;
                     if (at_max) ovf_q <= 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (clr_press) begin
                  state_q <= IDLE;
                  ovf_q   <= 1'b0;
                  min_q   <= 4'd0;
                  sect_q  <= 4'd0;
                  seco_q  <= 4'd0;
                  tenth_q <= 4'd0;
               end else if (ss_press) begin
                  state_q <= RUN;
                  run_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign running  = run_q;
   assign overflow = ovf_q;

`ifdef STOPWATCH_LAP_HOLD_EN
   logic        lap_prev_q;
   logic        lap_q;
   logic [15:0] hold_q;
   logic        lap_press;

   assign lap_press = btn_lap & ~lap_prev_q;

   // Hold can only be set in RUN; leaving RUN (stop) releases it.
   always_ff @(posedge clk) begin
      if (reset) begin
         lap_prev_q <= 1'b0;
         lap_q      <= 1'b0;
         hold_q     <= '0;
      end else begin
         lap_prev_q <= btn_lap;
         if (state_q == RUN) begin
            if (ss_press) begin
               lap_q <= 1'b0;
            end else if (lap_press) begin
               lap_q <= ~lap_q;
               if (!lap_q) hold_q <= {min_q, sect_q, seco_q, tenth_q};
            end
         end else if (state_q == PAUSE && clr_press) begin
            lap_q <= 1'b0;
         end
      end
   end

   assign {disp_min, disp_sec_t, disp_sec_o, disp_tenth} =
      lap_q ? hold_q : {min_q, sect_q, seco_q, tenth_q};
   assign lap_active = lap_q;
`else
   logic unused_lap;
   assign unused_lap = btn_lap;
   assign disp_min   = min_q;
   assign disp_sec_t = sect_q;
   assign disp_sec_o = seco_q;
   assign disp_tenth = tenth_q;
   assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed self-checking bench for stopwatch_core.
// Runs a saturating and a wrapping instance side by side on one stimulus.
module tb_stopwatch_core;

   logic clk = 1'b0;
   logic reset, tick_in, btn_ss, btn_clr, btn_lap;
   logic [3:0] s_min, s_sect, s_seco, s_tenth;
   logic [3:0] w_min, w_sect, w_seco, w_tenth;
   logic s_run, s_ovf, s_lap, w_run, w_ovf, w_lap;
   int   nchecks = 0;
   int   nerrs   = 0;
   int   w_ovf_cycles = 0;

   always #5 clk = ~clk;

   stopwatch_core #(.TICK_SYNC_STAGES(2), .WRAP_AT_MAX(1'b0)) u_sat (
      .clk(clk), .reset(reset), .tick_in(tick_in),
      .btn_start_stop(btn_ss), .btn_clear(btn_clr), .btn_lap(btn_lap),
      .disp_min(s_min), .disp_sec_t(s_sect), .disp_sec_o(s_seco),
      .disp_tenth(s_tenth), .running(s_run), .overflow(s_ovf),
      .lap_active(s_lap));

   stopwatch_core #(.TICK_SYNC_STAGES(2), .WRAP_AT_MAX(1'b1)) u_wrap (
      .clk(clk), .reset(reset), .tick_in(tick_in),
      .btn_start_stop(btn_ss), .btn_clear(btn_clr), .btn_lap(btn_lap),
      .disp_min(w_min), .disp_sec_t(w_sect), .disp_sec_o(w_seco),
      .disp_tenth(w_tenth), .running(w_run), .overflow(w_ovf),
      .lap_active(w_lap));

   always @(negedge clk) if (w_ovf) w_ovf_cycles++;

   function automatic logic [15:0] sdisp();
      return {s_min, s_sect, s_seco, s_tenth};
   endfunction

   function automatic logic [15:0] wdisp();
      return {w_min, w_sect, w_seco, w_tenth};
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk); tick_in = 1'b1;
      repeat (2) @(negedge clk);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press(input bit ss, input bit clr, input bit lap);
      @(negedge clk);
      btn_ss = ss; btn_clr = clr; btn_lap = lap;
      @(negedge clk);
      btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; tick_in = 1'b0;
      btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_disp", sdisp(), 16'h0000);
      check("rst_run", s_run, 0);
      check("rst_ovf", s_ovf, 0);
      check("rst_lap", s_lap, 0);

      // Count and carry, with latency on the last edge
      press(1, 0, 0);
      check("start_run", s_run, 1);
      ticks(598);
      check("cnt_598", sdisp(), 16'h0598);
      @(negedge clk); tick_in = 1'b1;
      repeat (3) @(negedge clk);
      check("lat_early", sdisp(), 16'h0598);
      @(negedge clk);
      check("lat_land", sdisp(), 16'h0599);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
      tick();
      check("carry_min", sdisp(), 16'h1000);
      ticks(234);
      check("cnt_1234", sdisp(), 16'h1234);

      // Reset mid-count
      @(negedge clk); reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("t1_disp", sdisp(), 16'h0000);
      check("t1_run", s_run, 0);
      check("t1_ovf", s_ovf, 0);
      check("t1_wdisp", wdisp(), 16'h0000);

      // FSM
      press(1, 0, 0);
      ticks(25);
      check("t3_25", sdisp(), 16'h0025);
      press(0, 1, 0);
      check("t3_clr_run", sdisp(), 16'h0025);
      check("t3_clr_run_r", s_run, 1);
      press(1, 0, 0);
      check("t3_stop", s_run, 0);
      ticks(10);
      check("t3_hold", sdisp(), 16'h0025);
      press(0, 1, 0);
      check("t3_clear", sdisp(), 16'h0000);
      check("t3_idle", s_run, 0);

      // Stop coincident with tick strobe
      press(1, 0, 0);
      ticks(3);
      check("t4_3", sdisp(), 16'h0003);
      @(negedge clk); tick_in = 1'b1;
      repeat (3) @(negedge clk);
      btn_ss = 1'b1;
      @(negedge clk);
      btn_ss = 1'b0; tick_in = 1'b0;
      repeat (2) @(negedge clk);
      check("t4_nocount", sdisp(), 16'h0003);
      check("t4_pause", s_run, 0);
      press(1, 1, 0);
      check("t4_both_disp", sdisp(), 16'h0000);
      check("t4_both_run", s_run, 0);
      press(1, 1, 0);
      check("t4_idle_both", s_run, 1);

      // Max handling
      ticks(5999);
      check("t5_max", sdisp(), 16'h9599);
      check("t5_max_w", wdisp(), 16'h9599);
      check("t5_noovf", s_ovf, 0);
      ticks(3);
      check("t5_sat", sdisp(), 16'h9599);
      check("t5_sat_ovf", s_ovf, 1);
      check("t5_wrap", wdisp(), 16'h0002);
      check("t5_wrap_ovf", w_ovf, 0);
      check("t5_pulse", w_ovf_cycles, 1);
      press(1, 0, 0);
      press(0, 1, 0);
      check("t5_clr_ovf", s_ovf, 0);
      check("t5_clr_disp", sdisp(), 16'h0000);

      // Lap hold
      press(1, 0, 0);
      ticks(40);
      press(0, 0, 1);
      ticks(30);
`ifdef STOPWATCH_LAP_HOLD_EN
      check("t6_hold", sdisp(), 16'h0040);
      check("t6_lap", s_lap, 1);
`else
      check("t6_hold", sdisp(), 16'h0070);
      check("t6_lap", s_lap, 0);
`endif
      press(0, 0, 1);
      check("t6_rel", sdisp(), 16'h0070);
      check("t6_rel_lap", s_lap, 0);
      press(1, 0, 0);
      press(0, 0, 1);
      check("t6_pause_lap", s_lap, 0);
      check("t6_pause_disp", sdisp(), 16'h0070);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
